// File: rtl/game_retract_ctrl_if.sv
// Command/move-engine/history handshake bundle for game_retract_ctrl.
// The slave modport is the controller side; the master modport is the keypad/engine/history side.
`timescale 1ns/1ps
interface game_retract_ctrl_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       mv_req;
    logic [1:0] mv_dir;
    logic       mv_done;
    logic       mv_ok;
    logic       mv_box;
    logic [1:0] sel;
    logic       game_state_en;
    logic [1:0] depth;
    logic [1:0] budget;
    logic       reject;

    modport master (
        output cmd_valid, cmd, mv_done, mv_ok, mv_box,
        input  cmd_ready, mv_req, mv_dir, sel, game_state_en, depth, budget, reject
    );

    modport slave (
        input  cmd_valid, cmd, mv_done, mv_ok, mv_box,
        output cmd_ready, mv_req, mv_dir, sel, game_state_en, depth, budget, reject
    );
endinterface

// File: rtl/game_retract_ctrl.sv
// Command sequencer for the 3-level retract history: commits moves, retracts, reloads the level.
// Optional per-level undo budget enabled by defining GAME_RETRACT_BUDGET_EN.
`timescale 1ns/1ps
module game_retract_ctrl #(
    parameter int DEPTH       = 3,
    parameter int RETRACT_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    game_retract_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        INIT      = 2'b00,
        IDLE      = 2'b01,
        MOVE_WAIT = 2'b10,
        COMMIT    = 2'b11
    } state_t;

    localparam logic [2:0] CMD_UNDO    = 3'b100;
    localparam logic [2:0] CMD_RESTART = 3'b101;
    localparam logic [1:0] SEL_INIT    = 2'b00;
    localparam logic [1:0] SEL_BOX     = 2'b01;
    localparam logic [1:0] SEL_MAN     = 2'b10;
    localparam logic [1:0] SEL_RETRACT = 2'b11;
    localparam logic [1:0] DEPTH_MAX   = 2'(DEPTH);
    localparam logic [1:0] BUDGET_MAX  = 2'(RETRACT_MAX);

    state_t     state_r, state_s;
    logic       cmd_ready_r, cmd_ready_s;
    logic       mv_req_r, mv_req_s;
    logic [1:0] mv_dir_r, mv_dir_s;
    logic [1:0] sel_r, sel_s;
    logic       en_r, en_s;
    logic [1:0] depth_r, depth_s;
    logic       reject_r, reject_s;
    logic       undo_ok_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] value, input logic [1:0] limit);
        logic [1:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 2'd1;
        end
        return result;
    endfunction

`ifdef GAME_RETRACT_BUDGET_EN
    logic [1:0] budget_r, budget_s;

    assign undo_ok_s  = (depth_r != 2'd0) && (budget_r != 2'd0);
    assign bus.budget = budget_r;
`else
    assign undo_ok_s  = (depth_r != 2'd0);
    assign bus.budget = BUDGET_MAX;
`endif

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = 1'b0;
        mv_req_s    = 1'b0;
        mv_dir_s    = mv_dir_r;
        sel_s       = sel_r;
        en_s        = 1'b0;
        depth_s     = depth_r;
        reject_s    = 1'b0;
`ifdef GAME_RETRACT_BUDGET_EN
        budget_s    = budget_r;
`endif
        case (state_r)
            INIT: begin
                // en_r low here only right after reset: issue the init strobe first.
                sel_s   = SEL_INIT;
                depth_s = 2'd0;
`ifdef GAME_RETRACT_BUDGET_EN
                budget_s = BUDGET_MAX;
`endif
                if (en_r) begin
                    state_s     = IDLE;
                    cmd_ready_s = 1'b1;
                end else begin
                    en_s = 1'b1;
                end
            end
            IDLE: begin
                cmd_ready_s = 1'b1;
                if (bus.cmd_valid) begin
                    case (bus.cmd)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_s     = MOVE_WAIT;
                            mv_dir_s    = bus.cmd[1:0];
                            mv_req_s    = 1'b1;
                            cmd_ready_s = 1'b0;
                        end
                        CMD_UNDO: begin
                            if (undo_ok_s) begin
                                state_s     = COMMIT;
                                sel_s       = SEL_RETRACT;
                                en_s        = 1'b1;
                                depth_s     = depth_r - 2'd1;
                                cmd_ready_s = 1'b0;
`ifdef GAME_RETRACT_BUDGET_EN
                                budget_s    = budget_r - 2'd1;
`endif
                            end else begin
                                reject_s = 1'b1;
                            end
                        end
                        CMD_RESTART: begin
                            state_s     = INIT;
                            sel_s       = SEL_INIT;
                            en_s        = 1'b1;
                            depth_s     = 2'd0;
                            cmd_ready_s = 1'b0;
`ifdef GAME_RETRACT_BUDGET_EN
                            budget_s    = BUDGET_MAX;
`endif
                        end
                        default: begin
                            cmd_ready_s = 1'b1;
                        end
                    endcase
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            MOVE_WAIT: begin
                if (bus.mv_done) begin
                    if (bus.mv_ok) begin
                        state_s = COMMIT;
                        sel_s   = bus.mv_box ? SEL_BOX : SEL_MAN;
                        en_s    = 1'b1;
                        depth_s = sat_inc(depth_r, DEPTH_MAX);
                    end else begin
                        state_s     = IDLE;
                        cmd_ready_s = 1'b1;
                    end
                end else begin
                    mv_req_s = 1'b1;
                end
            end
            COMMIT: begin
                state_s     = IDLE;
                cmd_ready_s = 1'b1;
            end
            default: begin
                state_s = INIT;
            end
        endcase
    end

    // State and output registers; reset drops mv_req immediately and abandons any pending move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= INIT;
            cmd_ready_r <= 1'b0;
            mv_req_r    <= 1'b0;
            mv_dir_r    <= 2'b00;
            sel_r       <= SEL_INIT;
            en_r        <= 1'b0;
            depth_r     <= 2'd0;
            reject_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            mv_req_r    <= mv_req_s;
            mv_dir_r    <= mv_dir_s;
            sel_r       <= sel_s;
            en_r        <= en_s;
            depth_r     <= depth_s;
            reject_r    <= reject_s;
        end
    end

`ifdef GAME_RETRACT_BUDGET_EN
    // Undo budget: reloaded only on level (re)start, spent by each accepted undo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            budget_r <= BUDGET_MAX;
        end else begin
            budget_r <= budget_s;
        end
    end
`endif

    assign bus.cmd_ready     = cmd_ready_r;
    assign bus.mv_req        = mv_req_r;
    assign bus.mv_dir        = mv_dir_r;
    assign bus.sel           = sel_r;
    assign bus.game_state_en = en_r;
    assign bus.depth         = depth_r;
    assign bus.reject        = reject_r;

endmodule

// File: tb/tb_game_retract_ctrl.sv
// Randomized self-checking bench for game_retract_ctrl against a transaction-level model
// of history depth, undo budget and the last committed history select.
`timescale 1ns/1ps
module tb_game_retract_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    game_retract_ctrl_if bus();

    game_retract_ctrl #(.DEPTH(3), .RETRACT_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef GAME_RETRACT_BUDGET_EN
    localparam bit BUDGET_EN = 1'b1;
`else
    localparam bit BUDGET_EN = 1'b0;
`endif
    localparam int MAX_DEPTH  = 3;
    localparam int MAX_BUDGET = 3;

    int total = 0;
    int bad   = 0;

    // Model: undo levels held, undos left, last select committed to history.
    int m_depth  = 0;
    int m_budget = MAX_BUDGET;
    int m_sel    = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_sel"},    int'(bus.sel),    m_sel);
        check_eq({tag, "_depth"},  int'(bus.depth),  m_depth);
        check_eq({tag, "_budget"}, int'(bus.budget), m_budget);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", int'(bus.cmd_ready === 1'b1), 1);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'b000;
        bus.mv_done   = 1'b0;
        bus.mv_ok     = 1'b0;
        bus.mv_box    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_en",     int'(bus.game_state_en), 0);
        check_eq("rst_ready",  int'(bus.cmd_ready),     0);
        check_eq("rst_mv_req", int'(bus.mv_req),        0);
        check_eq("rst_mv_dir", int'(bus.mv_dir),        0);
        check_eq("rst_reject", int'(bus.reject),        0);
        m_depth  = 0;
        m_budget = MAX_BUDGET;
        m_sel    = 0;
        check_model("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("init_strobe", int'(bus.game_state_en), 1);
        check_eq("init_ready",  int'(bus.cmd_ready),     0);
        check_model("init");
        @(negedge clk);
        check_eq("init_end_en",    int'(bus.game_state_en), 0);
        check_eq("init_end_ready", int'(bus.cmd_ready),     1);
        check_model("init_end");
    endtask

    task automatic do_cmd(input logic [2:0] c, input bit ok, input bit box, input int dly);
        bit exp_strobe;
        bit exp_rej;
        exp_strobe = 1'b0;
        exp_rej    = 1'b0;
        wait_ready();
        bus.cmd       = c;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (c[2] == 1'b0) begin
            check_eq("mv_req_rise", int'(bus.mv_req),    1);
            check_eq("mv_dir",      int'(bus.mv_dir),    int'(c[1:0]));
            check_eq("mv_ready_lo", int'(bus.cmd_ready), 0);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check_eq("mv_req_hold", int'(bus.mv_req), 1);
                check_eq("mv_dir_hold", int'(bus.mv_dir), int'(c[1:0]));
            end
            bus.mv_done = 1'b1;
            bus.mv_ok   = ok;
            bus.mv_box  = box;
            @(negedge clk);
            bus.mv_done = 1'b0;
            if (ok) begin
                exp_strobe = 1'b1;
                m_sel      = box ? 1 : 2;
                m_depth    = (m_depth < MAX_DEPTH) ? m_depth + 1 : MAX_DEPTH;
            end
            check_eq("mv_strobe",   int'(bus.game_state_en), int'(exp_strobe));
            check_eq("mv_req_fall", int'(bus.mv_req),        0);
            check_eq("mv_ready",    int'(bus.cmd_ready),     int'(!exp_strobe));
            check_model("mv");
        end else begin
            if (c == 3'b100) begin
                if (m_depth > 0 && (!BUDGET_EN || m_budget > 0)) begin
                    exp_strobe = 1'b1;
                    m_sel      = 3;
                    m_depth    = m_depth - 1;
                    if (BUDGET_EN) m_budget = m_budget - 1;
                end else begin
                    exp_rej = 1'b1;
                end
            end else if (c == 3'b101) begin
                exp_strobe = 1'b1;
                m_sel      = 0;
                m_depth    = 0;
                m_budget   = MAX_BUDGET;
            end
            check_eq("cmd_strobe", int'(bus.game_state_en), int'(exp_strobe));
            check_eq("cmd_reject", int'(bus.reject),        int'(exp_rej));
            check_eq("cmd_ready",  int'(bus.cmd_ready),     int'(!exp_strobe));
            check_model("cmd");
        end
        if (exp_strobe) begin
            @(negedge clk);
        end
        @(negedge clk);
        check_eq("post_en",     int'(bus.game_state_en), 0);
        check_eq("post_reject", int'(bus.reject),        0);
        check_eq("post_ready",  int'(bus.cmd_ready),     1);
        check_model("post");
    endtask

    task automatic stray_done();
        wait_ready();
        bus.mv_done = 1'b1;
        bus.mv_ok   = 1'b1;
        bus.mv_box  = 1'b1;
        @(negedge clk);
        bus.mv_done = 1'b0;
        @(negedge clk);
        check_eq("stray_en",    int'(bus.game_state_en), 0);
        check_eq("stray_mvreq", int'(bus.mv_req),        0);
        check_model("stray");
    endtask

    initial begin
        int r;
        logic [2:0] c;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'b000;
        bus.mv_done   = 1'b0;
        bus.mv_ok     = 1'b0;
        bus.mv_box    = 1'b0;
        do_reset();

        // Move right, engine answers after four cycles.
        do_cmd(3'b011, 1'b1, 1'b0, 4);
        do_cmd(3'b000, 1'b1, 1'b0, 1);
        do_cmd(3'b001, 1'b1, 1'b0, 0);
        do_cmd(3'b010, 1'b1, 1'b1, 2);
        do_cmd(3'b000, 1'b0, 1'b1, 3);
        repeat (4) do_cmd(3'b100, 1'b0, 1'b0, 0);
        do_cmd(3'b110, 1'b0, 1'b0, 0);
        do_cmd(3'b111, 1'b0, 1'b0, 0);
        stray_done();

        // Budget exhaustion with history still available.
        do_cmd(3'b101, 1'b0, 1'b0, 0);
        repeat (3) do_cmd(3'b001, 1'b1, 1'b0, 1);
        repeat (3) do_cmd(3'b100, 1'b0, 1'b0, 0);
        repeat (3) do_cmd(3'b010, 1'b1, 1'b1, 1);
        do_cmd(3'b100, 1'b0, 1'b0, 0);

        // Restart, then reset in the middle of a pending move.
        do_cmd(3'b101, 1'b0, 1'b0, 0);
        do_cmd(3'b011, 1'b1, 1'b0, 1);
        wait_ready();
        bus.cmd       = 3'b001;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_eq("abort_mv_req", int'(bus.mv_req), 1);
        #2 rst_n = 1'b0;
        #1 check_eq("abort_drop", int'(bus.mv_req), 0);
        do_reset();

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                c = 3'($urandom_range(0, 3));
                do_cmd(c, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 5)));
            end else if (r < 85) begin
                do_cmd(3'b100, 1'b0, 1'b0, 0);
            end else if (r < 90) begin
                do_cmd(3'b101, 1'b0, 1'b0, 0);
            end else if (r < 95) begin
                c = 3'($urandom_range(6, 7));
                do_cmd(c, 1'b0, 1'b0, 0);
            end else begin
                stray_done();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
